// File: rtl/vga_fb_arbiter_pkg.sv
// Shared types and 640x480@60 timing constants for the tile framebuffer arbiter.
package vga_fb_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WRITE = 2'd2
   } arb_state_t;

   localparam logic [10:0] H_VISIBLE  = 11'd640;
   localparam logic [10:0] V_VISIBLE  = 11'd480;
   localparam logic [10:0] H_LAST     = 11'd800;
   localparam logic [10:0] V_LAST     = 11'd525;
   localparam logic [10:0] H_PREFETCH = 11'd796;

   localparam int TILE_SHIFT = 3;
   localparam int FB_DEPTH   = 4800;

   // In-line fetches stop one tile before the end of the visible line.
   localparam logic [10:0] H_FETCH_END = H_VISIBLE - 11'(1 << TILE_SHIFT);

   // Phases within a tile: fetch the following tile mid-tile, swap it in on the last pixel.
   localparam logic [TILE_SHIFT-1:0] TILE_FETCH_PHASE = TILE_SHIFT'(4);
   localparam logic [TILE_SHIFT-1:0] TILE_SWAP_PHASE  = TILE_SHIFT'(7);

endpackage

// File: rtl/vga_tile_addr_gen.sv
// Combinational decode of fetch decision cycles, fetch target and tile swap points.
module vga_tile_addr_gen
   import vga_fb_arbiter_pkg::*;
#(
   parameter int TILES_X = 80,
   parameter int TILES_Y = 60
) (
   input  logic [10:0] hcounter,
   input  logic [10:0] vcounter,
   output logic        fetch_now,
   output logic [12:0] fetch_addr,
   output logic        tile_swap,
   output logic        pixel_visible
);

   logic [10:0] next_line;
   logic [12:0] row_cur;
   logic [12:0] row_next;
   logic [12:0] col_next;
   logic        in_line_fetch;
   logic        line_start_fetch;

   // Decide whether this cycle fetches, which tile it targets, and when the tile registers swap.
   always_comb begin
      next_line        = (vcounter == V_LAST) ? 11'd0 : vcounter + 11'd1;
      row_cur          = 13'(vcounter >> TILE_SHIFT);
      row_next         = 13'(next_line >> TILE_SHIFT);
      col_next         = 13'(hcounter >> TILE_SHIFT) + 13'd1;
      in_line_fetch    = (hcounter[TILE_SHIFT-1:0] == TILE_FETCH_PHASE) &&
                         (hcounter < H_FETCH_END) && (vcounter < V_VISIBLE) &&
                         (row_cur < 13'(TILES_Y));
      line_start_fetch = (hcounter == H_PREFETCH) && (next_line < V_VISIBLE) &&
                         (row_next < 13'(TILES_Y));
      fetch_now        = in_line_fetch || line_start_fetch;
      fetch_addr       = line_start_fetch ? row_next * 13'(TILES_X)
                                          : row_cur * 13'(TILES_X) + col_next;
      tile_swap        = ((hcounter[TILE_SHIFT-1:0] == TILE_SWAP_PHASE) && (hcounter < H_FETCH_END)) ||
                         (hcounter == H_LAST);
      pixel_visible    = (hcounter < H_VISIBLE) && (vcounter < V_VISIBLE);
   end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Arbitrates one single-port tile RAM between VGA scan-out fetches and a writer port.
module vga_fb_arbiter
   import vga_fb_arbiter_pkg::*;
#(
   parameter int TILES_X  = 80,
   parameter int TILES_Y  = 60,
   parameter int FB_DEPTH = vga_fb_arbiter_pkg::FB_DEPTH
) (
   input  logic        pixel_clk,
   input  logic        rst_n,
   input  logic [10:0] hcounter,
   input  logic [10:0] vcounter,
   input  logic        wr_req,
   input  logic [12:0] wr_addr,
   input  logic [11:0] wr_data,
   output logic        wr_ack,
   output logic        wr_err,
   output logic [12:0] mem_addr,
   output logic        mem_we,
   output logic [11:0] mem_wdata,
   input  logic [11:0] mem_rdata,
   output logic [11:0] rgb
);

   arb_state_t  state;
   arb_state_t  state_next;
   logic        fetch_now;
   logic [12:0] fetch_addr;
   logic        tile_swap;
   logic        pixel_visible;
   logic        addr_ok;
   logic [12:0] addr_next;
   logic        we_next;
   logic [11:0] wdata_next;
   logic        ack_next;
   logic        err_next;
   logic        fetch_pending;
   logic [11:0] next_tile;
   logic [11:0] cur_tile;

   vga_tile_addr_gen #(
      .TILES_X(TILES_X),
      .TILES_Y(TILES_Y)
   ) u_addr_gen (
      .hcounter     (hcounter),
      .vcounter     (vcounter),
      .fetch_now    (fetch_now),
      .fetch_addr   (fetch_addr),
      .tile_swap    (tile_swap),
      .pixel_visible(pixel_visible)
   );

   // Next state and RAM command: a fetch always wins, and a write never follows a write.
   always_comb begin
      state_next = IDLE;
      addr_next  = '0;
      we_next    = 1'b0;
      wdata_next = '0;
      ack_next   = 1'b0;
      err_next   = wr_err;
      addr_ok    = ({1'b0, wr_addr} < 14'(FB_DEPTH));
      if (fetch_now) begin
         state_next = FETCH;
         addr_next  = fetch_addr;
      end else if (wr_req && (state != WRITE)) begin
         state_next = WRITE;
         addr_next  = wr_addr;
         we_next    = addr_ok;
         wdata_next = wr_data;
         ack_next   = 1'b1;
         err_next   = wr_err | ~addr_ok;
      end
   end

   // State register; mem_* outputs and the ack are registered alongside it.
   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         wr_ack    <= 1'b0;
         wr_err    <= 1'b0;
      end else begin
         state     <= state_next;
         mem_addr  <= addr_next;
         mem_we    <= we_next;
         mem_wdata <= wdata_next;
         wr_ack    <= ack_next;
         wr_err    <= err_next;
      end
   end

   // Tile pipeline: latch RAM data the cycle after a fetch, promote it at a tile boundary.
   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pending <= 1'b0;
         next_tile     <= '0;
         cur_tile      <= '0;
      end else begin
         fetch_pending <= (state == FETCH);
         if (fetch_pending) begin
            next_tile <= mem_rdata;
         end
         if (tile_swap) begin
            cur_tile <= next_tile;
         end
      end
   end

   // Pixel register, forced to black outside the visible area.
   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb <= '0;
      end else begin
         rgb <= pixel_visible ? cur_tile : 12'd0;
      end
   end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter with a behavioural single-port RAM.
module tb_vga_fb_arbiter;
   import vga_fb_arbiter_pkg::*;

   logic        pixel_clk;
   logic        rst_n;
   logic [10:0] hcounter;
   logic [10:0] vcounter;
   logic        wr_req;
   logic [12:0] wr_addr;
   logic [11:0] wr_data;
   logic        wr_ack;
   logic        wr_err;
   logic [12:0] mem_addr;
   logic        mem_we;
   logic [11:0] mem_wdata;
   logic [11:0] mem_rdata;
   logic [11:0] rgb;

   typedef struct {
      logic [12:0] addr;
      logic [11:0] data;
   } wr_txn_t;

   logic [11:0] ram [0:8191];
   int          n_checks = 0;
   int          n_errors = 0;
   int          rgb_q[$];
   wr_txn_t     wr_q[$];

   vga_fb_arbiter #(
      .TILES_X (80),
      .TILES_Y (60),
      .FB_DEPTH(4800)
   ) dut (
      .pixel_clk(pixel_clk),
      .rst_n    (rst_n),
      .hcounter (hcounter),
      .vcounter (vcounter),
      .wr_req   (wr_req),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_ack   (wr_ack),
      .wr_err   (wr_err),
      .mem_addr (mem_addr),
      .mem_we   (mem_we),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .rgb      (rgb)
   );

   // Free-running pixel clock.
   initial begin
      pixel_clk = 1'b0;
      forever #5 pixel_clk = ~pixel_clk;
   end

   // External synchronous RAM: read data appears one cycle after the address.
   always @(posedge pixel_clk) begin
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] = mem_wdata;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed timeout, expected summary before 1000000");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      n_checks++;
      if (observed !== expected) begin
         n_errors++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge pixel_clk);
      #1;
   endtask

   function automatic int expectedRgb(input int h, input int v);
      if (h < 640 && v < 480) return ((v >> 3) * 80 + (h >> 3)) & 'hFFF;
      return 0;
   endfunction

   task automatic presentWrite(input int addr, input int data);
      wr_txn_t t;
      t.addr  = 13'(addr);
      t.data  = 12'(data);
      wr_addr = t.addr;
      wr_data = t.data;
      wr_req  = 1'b1;
      wr_q.push_back(t);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_ack"},   int'(wr_ack), 0);
      checkOutput({tag, "_err"},   int'(wr_err), 0);
      checkOutput({tag, "_addr"},  int'(mem_addr), 0);
      checkOutput({tag, "_we"},    int'(mem_we), 0);
      checkOutput({tag, "_wdata"}, int'(mem_wdata), 0);
      checkOutput({tag, "_rgb"},   int'(rgb), 0);
      checkOutput({tag, "_state"}, int'(dut.state), int'(IDLE));
   endtask

   // Drives the timing counters from (v0,h0) for n cycles, scoreboarding rgb and optionally a writer stream.
   task automatic applyStimulus(input int v0, input int h0, input int n, input bit use_writer);
      int      h = h0;
      int      v = v0;
      int      wait_edges = 0;
      int      bound = 2;
      int      gap = 100;
      int      next_addr = 3200;
      wr_txn_t t;
      if (use_writer) begin
         presentWrite(next_addr, next_addr * 5);
         next_addr++;
      end
      for (int i = 0; i < n; i++) begin
         hcounter = 11'(h);
         vcounter = 11'(v);
         rgb_q.push_back(expectedRgb(h, v));
         tick();
         checkOutput("rgb", int'(rgb), rgb_q.pop_front());
         gap++;
         if (!use_writer) begin
            checkOutput("idle_ack", int'(wr_ack), 0);
         end else begin
            wait_edges++;
            if (wr_ack) begin
               t = wr_q.pop_front();
               checkOutput("stream_addr",  int'(mem_addr), int'(t.addr));
               checkOutput("stream_we",    int'(mem_we), 1);
               checkOutput("stream_wdata", int'(mem_wdata), int'(t.data));
               checkOutput("stream_latency_ok", int'(wait_edges <= bound), 1);
               checkOutput("stream_gap_ok", int'(gap >= 2), 1);
               gap        = 0;
               wait_edges = 0;
               bound      = 3;
               presentWrite(next_addr, next_addr * 5);
               next_addr++;
            end else if (wait_edges > 3) begin
               checkOutput("stream_ack_timeout", wait_edges, 3);
               t          = wr_q.pop_front();
               wait_edges = 0;
               presentWrite(next_addr, next_addr * 5);
               next_addr++;
            end
         end
         h++;
         if (h > 800) begin
            h = 0;
            v = (v == 525) ? 0 : v + 1;
         end
      end
      if (use_writer) begin
         wr_req = 1'b0;
         checkOutput("stream_outstanding", wr_q.size(), 1);
         wr_q.delete();
         checkOutput("stream_err", int'(wr_err), 0);
      end
   endtask

   initial begin
      wr_txn_t t;
      int      acks;
      int      first_ack;

      rst_n    = 1'b0;
      hcounter = 11'd700;
      vcounter = 11'd0;
      wr_req   = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      for (int k = 0; k < 8192; k++) ram[k] = 12'(k);

      // Reset values.
      tick();
      tick();
      checkAllZero("reset");
      rst_n = 1'b1;
      tick();
      checkOutput("release_we", int'(mem_we), 0);

      // Write request colliding with an in-line fetch: fetch tile 1 first, then ack.
      hcounter = 11'd4;
      vcounter = 11'd0;
      presentWrite(3300, 'hABC);
      tick();
      checkOutput("collide_state", int'(dut.state), int'(FETCH));
      checkOutput("collide_fetch_addr", int'(mem_addr), 1);
      checkOutput("collide_fetch_we", int'(mem_we), 0);
      checkOutput("collide_no_ack", int'(wr_ack), 0);
      hcounter = 11'd5;
      tick();
      t = wr_q.pop_front();
      checkOutput("collide_ack", int'(wr_ack), 1);
      checkOutput("collide_wr_addr", int'(mem_addr), int'(t.addr));
      checkOutput("collide_wr_we", int'(mem_we), 1);
      checkOutput("collide_wr_data", int'(mem_wdata), int'(t.data));
      wr_req   = 1'b0;
      hcounter = 11'd6;
      tick();
      checkOutput("ack_single_cycle", int'(wr_ack), 0);
      checkOutput("err_clean", int'(wr_err), 0);

      // Line-start prefetch boundaries.
      hcounter = 11'd796;
      vcounter = 11'd7;
      tick();
      checkOutput("prefetch_v7_state", int'(dut.state), int'(FETCH));
      checkOutput("prefetch_v7_addr", int'(mem_addr), 80);
      checkOutput("prefetch_v7_we", int'(mem_we), 0);
      hcounter = 11'd700;
      tick();
      hcounter = 11'd796;
      vcounter = 11'd479;
      tick();
      checkOutput("prefetch_v479_none", int'(dut.state == FETCH), 0);
      vcounter = 11'd525;
      tick();
      checkOutput("prefetch_v525_state", int'(dut.state), int'(FETCH));
      checkOutput("prefetch_v525_addr", int'(mem_addr), 0);
      hcounter = 11'd700;
      vcounter = 11'd0;
      tick();

      // Out-of-range write: acked, not written, sticky error.
      presentWrite(4800, 'h123);
      tick();
      t = wr_q.pop_front();
      checkOutput("oor_ack", int'(wr_ack), 1);
      checkOutput("oor_we", int'(mem_we), 0);
      checkOutput("oor_addr", int'(mem_addr), int'(t.addr));
      checkOutput("oor_err", int'(wr_err), 1);
      wr_req = 1'b0;
      repeat (3) tick();
      checkOutput("oor_err_sticky", int'(wr_err), 1);
      checkOutput("oor_ack_gone", int'(wr_ack), 0);
      presentWrite(3301, 'h321);
      tick();
      t = wr_q.pop_front();
      checkOutput("after_oor_ack", int'(wr_ack), 1);
      checkOutput("after_oor_we", int'(mem_we), 1);
      checkOutput("after_oor_err", int'(wr_err), 1);
      wr_req = 1'b0;
      tick();

      // Reset asserted during a WRITE cycle; the held request completes once after release.
      presentWrite(3400, 'h5A5);
      tick();
      checkOutput("pre_reset_ack", int'(wr_ack), 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkAllZero("async_reset");
      tick();
      checkAllZero("held_reset");
      rst_n     = 1'b1;
      acks      = 0;
      first_ack = -1;
      t         = wr_q.pop_front();
      for (int i = 0; i < 6; i++) begin
         tick();
         if (wr_ack) begin
            acks++;
            if (acks == 1) begin
               first_ack = i;
               checkOutput("retry_addr", int'(mem_addr), int'(t.addr));
               checkOutput("retry_we", int'(mem_we), 1);
               checkOutput("retry_data", int'(mem_wdata), int'(t.data));
            end
            wr_req = 1'b0;
         end
      end
      wr_req = 1'b0;
      checkOutput("retry_acks", acks, 1);
      checkOutput("retry_first_edge", first_ack, 0);
      checkOutput("retry_err", int'(wr_err), 0);

      // Scan-out: frame wrap into lines 0-1, row change at lines 7-8, last visible line into blanking.
      applyStimulus(525, 780, 21 + 801 * 2, 1'b0);
      applyStimulus(6,   780, 21 + 801 * 2, 1'b0);
      applyStimulus(478, 780, 21 + 801 * 2, 1'b0);

      // Continuous writer stream to undisplayed rows while lines 7-8 scan out.
      applyStimulus(6, 780, 21 + 801 * 2, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
